// File: rtl/stream_unpack.sv
// Purpose : splits a header/payload word stream into per-channel entries tagged with channel and last-of-frame.
// Latency : 1 cycle from input handshake to o_valid (single output register stage).
// Backpressure: s_ready = !o_valid || o_ready; headers and dropped words also wait on the output stage.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   s_valid/s_ready     inbound word handshake; s_data is {addr, data} or a header word
//                       (header: s_data[31:16] == DATA_HEAD, s_data[15:0] = channel id)
//   max_count           payload words per frame (0 = unlimited), sampled when a header is taken
//   o_valid/o_ready     decoded-entry handshake; o_channel/o_addr/o_data/o_last the entry
//   frame_err           one-cycle pulse: dropped word, bad-channel header or short frame
//   seq_err             one-cycle pulse: header channel out of round-robin order
//   frame_cnt           number of o_last entries handed off, wraps at 2^32
//
// Optional feature: define UNPACK_SEQ_CHECK_EN to build the channel-sequence checker;
// without it seq_err is tied low and no sequence state exists.
// The header tag lives in bits [31:16], so ADDR_WIDTH+DATA_WIDTH must be at least 32.

module stream_unpack #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 16,
    parameter int          CHANNEL    = 8,
    parameter logic [15:0] DATA_HEAD  = 16'hA5A5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_data,
    input  logic [31:0]                      max_count,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic [15:0]                      o_channel,
    output logic [ADDR_WIDTH-1:0]            o_addr,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_last,
    output logic                             frame_err,
    output logic                             seq_err,
    output logic [31:0]                      frame_cnt
);

    localparam int          W      = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [16:0] CH_LIM = 17'(CHANNEL);

    typedef enum logic {IDLE, BODY} state_t;

    state_t      state_q, state_d;
    logic [15:0] chan_q;
    logic [31:0] max_q;
    logic [31:0] cnt_q;

    logic        in_fire;
    logic        is_head;
    logic [15:0] hdr_ch;
    logic        ch_ok;

    // FSM decisions for the word being consumed this cycle
    logic        take_hdr;
    logic        emit;
    logic        emit_last;
    logic        ferr_d;

    assign s_ready = !o_valid || o_ready;
    assign in_fire = s_valid && s_ready;
    assign is_head = (s_data[31:16] == DATA_HEAD);
    assign hdr_ch  = s_data[15:0];
    assign ch_ok   = (hdr_ch != 16'd0) && ({1'b0, hdr_ch} < CH_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_hdr  = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        ferr_d    = 1'b0;
        if (in_fire) begin
            case (state_q)
                IDLE: begin
                    if (is_head && ch_ok) begin
                        take_hdr = 1'b1;
                        state_d  = BODY;
                    end else begin
                        // stray payload or bad header: swallow it and flag
                        ferr_d = 1'b1;
                    end
                end
                BODY: begin
                    if (is_head) begin
                        if (ch_ok) begin
                            take_hdr = 1'b1;
                            state_d  = BODY;
                            // a bounded frame cut short by a new header
                            ferr_d   = (max_q != 32'd0) && (cnt_q != max_q);
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        emit      = 1'b1;
                        emit_last = (max_q != 32'd0) && ((cnt_q + 32'd1) == max_q);
                        if (emit_last) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // frame context: channel, length limit and running word count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q <= 16'd0;
            max_q  <= 32'd0;
            cnt_q  <= 32'd0;
        end else if (take_hdr) begin
            chan_q <= hdr_ch;
            max_q  <= max_count;
            cnt_q  <= 32'd0;
        end else if (emit) begin
            cnt_q  <= cnt_q + 32'd1;
        end
    end

    // output register stage; fields only load with a new entry so they hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_channel <= 16'd0;
            o_addr    <= '0;
            o_data    <= '0;
        end else if (s_ready) begin
            o_valid <= emit;
            if (emit) begin
                o_last    <= emit_last;
                o_channel <= chan_q;
                o_addr    <= s_data[W-1:DATA_WIDTH];
                o_data    <= s_data[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            frame_cnt <= 32'd0;
        end else begin
            frame_err <= ferr_d;
            if (o_valid && o_ready && o_last) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

`ifdef UNPACK_SEQ_CHECK_EN
    localparam logic [15:0] CH_MAX = 16'(CHANNEL - 1);

    // seq_have_q stays low until the first accepted header, so that one matches anything
    logic        seq_have_q;
    logic [15:0] seq_prev_q;
    logic [15:0] seq_exp;

    assign seq_exp = (seq_prev_q == CH_MAX) ? 16'd1 : (seq_prev_q + 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_have_q <= 1'b0;
            seq_prev_q <= 16'd0;
            seq_err    <= 1'b0;
        end else begin
            seq_err <= take_hdr && seq_have_q && (hdr_ch != seq_exp);
            if (take_hdr) begin
                seq_have_q <= 1'b1;
                seq_prev_q <= hdr_ch;
            end
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule
